// File: rtl/clint_smp.sv
// rtl/clint_smp.sv - core-local interruptor: mtime, per-hart mtimecmp/msip, 32-bit register slave
module clint_smp #(
    parameter int N_HARTS  = 1,
    parameter int TICK_DIV = 100
) (
    input  logic               CLK,
    input  logic               RST_X,
    input  logic               w_req,
    input  logic               w_we,
    input  logic [15:0]        w_addr,
    input  logic [31:0]        w_wdata,
    output logic [31:0]        r_rdata,
    output logic               r_ack,
    output logic               w_busy,
    output logic [63:0]        w_mtime,
    output logic [N_HARTS-1:0] w_mtip,
    output logic [N_HARTS-1:0] w_msip
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e             state_q, state_d;
    logic [13:0]        waddr_q, waddr_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [63:0]        mtime_q, mtime_d;
    logic [63:0]        cmp_q [N_HARTS];
    logic [63:0]        cmp_d [N_HARTS];
    logic [N_HARTS-1:0] msip_q, msip_d;
    logic [N_HARTS-1:0] mtip_q, mtip_d;

    logic        tick;
    logic [13:0] cmp_off;
    logic [31:0] msip_idx, cmp_idx;
    logic        is_msip, is_cmp, is_mtime;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^w_addr[1:0];

    // Decode works on the latched word address; the byte lanes are never used.
    assign tick     = (div_q == DIV_MAX);
    assign cmp_off  = waddr_q - 14'h1000;
    assign msip_idx = 32'(waddr_q[11:0]);
    assign cmp_idx  = 32'(cmp_off[13:1]);
    assign is_msip  = (waddr_q[13:12] == 2'b00) && (msip_idx < N_HARTS);
    assign is_cmp   = (waddr_q >= 14'h1000) && (waddr_q < 14'h2FFE) && (cmp_idx < N_HARTS);
    assign is_mtime = (waddr_q[13:1] == 13'h17FF);

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
        msip_d  = msip_q;
        cmp_d   = cmp_q;
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        for (int h = 0; h < N_HARTS; h++) begin
            mtip_d[h] = (mtime_q >= cmp_q[h]);
        end

        case (state_q)
            IDLE: begin
                if (w_req) begin
                    state_d = ACCESS;
                    waddr_d = w_addr[15:2];
                    we_d    = w_we;
                    wdata_d = w_wdata;
                    busy_d  = 1'b1;
                end
            end
            ACCESS: begin
                state_d = RESP;
                ack_d   = 1'b1;
                rdata_d = '0;
                if (we_q) begin
                    // A software write to mtime overrides a coincident tick.
                    if (is_mtime) begin
                        mtime_d = waddr_q[0] ? {wdata_q, mtime_q[31:0]} : {mtime_q[63:32], wdata_q};
                    end
                    for (int h = 0; h < N_HARTS; h++) begin
                        if (is_msip && msip_idx == h) begin
                            msip_d[h] = wdata_q[0];
                        end
                        if (is_cmp && cmp_idx == h) begin
                            cmp_d[h] = cmp_off[0] ? {wdata_q, cmp_q[h][31:0]} : {cmp_q[h][63:32], wdata_q};
                        end
                    end
                end else begin
                    if (is_mtime) begin
                        rdata_d = waddr_q[0] ? mtime_q[63:32] : mtime_q[31:0];
                    end
                    for (int h = 0; h < N_HARTS; h++) begin
                        if (is_msip && msip_idx == h) begin
                            rdata_d = {31'b0, msip_q[h]};
                        end
                        if (is_cmp && cmp_idx == h) begin
                            rdata_d = cmp_off[0] ? cmp_q[h][63:32] : cmp_q[h][31:0];
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= IDLE;
            waddr_q <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            div_q   <= '0;
            mtime_q <= '0;
            msip_q  <= '0;
            mtip_q  <= '0;
            for (int h = 0; h < N_HARTS; h++) begin
                cmp_q[h] <= '1;
            end
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            div_q   <= div_d;
            mtime_q <= mtime_d;
            msip_q  <= msip_d;
            mtip_q  <= mtip_d;
            cmp_q   <= cmp_d;
        end
    end

    assign r_rdata = rdata_q;
    assign r_ack   = ack_q;
    assign w_busy  = busy_q;
    assign w_mtime = mtime_q;
    assign w_mtip  = mtip_q;
    assign w_msip  = msip_q;

endmodule

// File: tb/tb_clint_smp.sv
// tb/tb_clint_smp.sv - bench for clint_smp: two parameterisations sharing one bus, checked against a model
module tb_clint_smp;

    logic        CLK = 1'b0;
    logic        RST_X = 1'b0;
    logic        w_req = 1'b0;
    logic        w_we = 1'b0;
    logic [15:0] w_addr = '0;
    logic [31:0] w_wdata = '0;

    logic [31:0] rdata_a, rdata_b;
    logic        ack_a, ack_b, busy_a, busy_b;
    logic [63:0] mtime_a, mtime_b;
    logic [1:0]  mtip_a, msip_a;
    logic [0:0]  mtip_b, msip_b;

    clint_smp #(.N_HARTS(2), .TICK_DIV(4)) dut_a (
        .CLK(CLK), .RST_X(RST_X), .w_req(w_req), .w_we(w_we), .w_addr(w_addr), .w_wdata(w_wdata),
        .r_rdata(rdata_a), .r_ack(ack_a), .w_busy(busy_a), .w_mtime(mtime_a), .w_mtip(mtip_a), .w_msip(msip_a)
    );

    clint_smp #(.N_HARTS(1), .TICK_DIV(1)) dut_b (
        .CLK(CLK), .RST_X(RST_X), .w_req(w_req), .w_we(w_we), .w_addr(w_addr), .w_wdata(w_wdata),
        .r_rdata(rdata_b), .r_ack(ack_b), .w_busy(busy_b), .w_mtime(mtime_b), .w_mtip(mtip_b), .w_msip(msip_b)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: index 0 = dut_a (2 harts, /4), index 1 = dut_b (1 hart, /1)
    function automatic int nh_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int td_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp [2][2];
    logic [1:0]  m_msip [2];
    logic [1:0]  m_mtip [2];
    int          m_cyc;
    logic        pend_v = 1'b0;
    logic [15:0] pend_addr = '0;
    logic [31:0] pend_data = '0;
    logic        in_resp = 1'b0;

    // kind: 0 unmapped, 1 msip, 2 mtimecmp, 3 mtime
    function automatic void dec(input int nh, input logic [15:0] addr, output int kind, output int h, output int half);
        int a;
        a = int'(addr) & 'hFFFC;
        kind = 0; h = 0; half = 0;
        if (a < 4 * nh) begin
            kind = 1; h = a / 4;
        end else if (a >= 'h4000 && a < 'h4000 + 8 * nh) begin
            kind = 2; h = (a - 'h4000) / 8; half = (a / 4) % 2;
        end else if (a == 'hBFF8 || a == 'hBFFC) begin
            kind = 3; half = (a / 4) % 2;
        end
    endfunction

    function automatic logic [31:0] model_rd(input int k, input logic [15:0] addr);
        int kind, h, half;
        dec(nh_of(k), addr, kind, h, half);
        case (kind)
            1: return {31'b0, m_msip[k][h]};
            2: return half ? m_cmp[k][h][63:32] : m_cmp[k][h][31:0];
            3: return half ? m_mtime[k][63:32] : m_mtime[k][31:0];
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge CLK) begin : model
        logic [63:0] nt, nc;
        int kind, h, half;
        logic wrote;
        if (!RST_X) begin
            m_cyc <= 0;
            for (int k = 0; k < 2; k++) begin
                m_mtime[k] <= '0;
                m_msip[k]  <= '0;
                m_mtip[k]  <= '0;
                for (int j = 0; j < 2; j++) m_cmp[k][j] <= '1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < 2; j++)
                    m_mtip[k][j] <= (j < nh_of(k)) && (m_mtime[k] >= m_cmp[k][j]);
                nt = m_mtime[k];
                wrote = 1'b0;
                if (pend_v) begin
                    dec(nh_of(k), pend_addr, kind, h, half);
                    if (kind == 1) m_msip[k][h] <= pend_data[0];
                    else if (kind == 2) begin
                        nc = m_cmp[k][h];
                        if (half != 0) nc[63:32] = pend_data; else nc[31:0] = pend_data;
                        m_cmp[k][h] <= nc;
                    end else if (kind == 3) begin
                        if (half != 0) nt[63:32] = pend_data; else nt[31:0] = pend_data;
                        wrote = 1'b1;
                    end
                end
                if (!wrote && (m_cyc % td_of(k)) == td_of(k) - 1) nt = nt + 64'd1;
                m_mtime[k] <= nt;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    always @(posedge CLK) begin
        #1;
        if (RST_X) begin
            check("mtime_a", mtime_a, m_mtime[0]);
            check("mtime_b", mtime_b, m_mtime[1]);
            check("mtip_a", 64'(mtip_a), 64'(m_mtip[0]));
            check("mtip_b", 64'(mtip_b), 64'(m_mtip[1][0]));
            check("msip_a", 64'(msip_a), 64'(m_msip[0]));
            check("msip_b", 64'(msip_b), 64'(m_msip[1][0]));
        end
    end

    task automatic do_reset();
        RST_X = 1'b0;
        w_req = 1'b0;
        #1;
        check("rst_ack", 64'(ack_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_rdata", 64'(rdata_a), 64'd0);
        check("rst_mtime", mtime_a, 64'd0);
        check("rst_mtip", 64'(mtip_a), 64'd0);
        check("rst_msip", 64'(msip_a), 64'd0);
        repeat (2) @(negedge CLK);
        RST_X = 1'b1;
        in_resp = 1'b0;
    endtask

    task automatic idle(input int n);
        w_req = 1'b0;
        repeat (n) @(negedge CLK);
        if (n > 0) in_resp = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge of the r_ack cycle.
    task automatic bus(input logic we, input logic [15:0] addr, input logic [31:0] data,
                       output logic [31:0] rd_a, output logic [31:0] rd_b);
        logic [31:0] ea, eb;
        w_req = 1'b1; w_we = we; w_addr = addr; w_wdata = data;
        if (in_resp) @(negedge CLK);
        check("busy_before", 64'(busy_a), 64'd0);
        @(negedge CLK);
        check("busy_access", 64'(busy_a), 64'd1);
        check("ack_early", 64'(ack_a), 64'd0);
        ea = model_rd(0, addr);
        eb = model_rd(1, addr);
        pend_v = we; pend_addr = addr; pend_data = data;
        @(negedge CLK);
        pend_v = 1'b0;
        check("ack_a", 64'(ack_a), 64'd1);
        check("ack_b", 64'(ack_b), 64'd1);
        check("busy_resp", 64'(busy_b), 64'd1);
        rd_a = rdata_a;
        rd_b = rdata_b;
        if (!we) begin
            check("rdata_a", 64'(rd_a), 64'(ea));
            check("rdata_b", 64'(rd_b), 64'(eb));
        end
        w_req = 1'b0;
        in_resp = 1'b1;
    endtask

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [1:0]  msip_a;
        logic        msip_b;
    } vec_t;

    vec_t        tbl [19];
    logic [15:0] alist [12] = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008,
                                16'h400C, 16'h4010, 16'hBFF8, 16'hBFFC, 16'h8000, 16'h0002};

    initial begin
        logic [31:0] ra, rb, d;
        int t;

        tbl[0]  = '{1'b1, 16'h0004, 32'h1,        32'h0,        32'h0,        2'b10, 1'b0};
        tbl[1]  = '{1'b0, 16'h0004, 32'h0,        32'h1,        32'h0,        2'b10, 1'b0};
        tbl[2]  = '{1'b0, 16'h0000, 32'h0,        32'h0,        32'h0,        2'b10, 1'b0};
        tbl[3]  = '{1'b1, 16'h0004, 32'h0,        32'h0,        32'h0,        2'b00, 1'b0};
        tbl[4]  = '{1'b0, 16'h0004, 32'h0,        32'h0,        32'h0,        2'b00, 1'b0};
        tbl[5]  = '{1'b1, 16'h0000, 32'hFFFFFFFF, 32'h0,        32'h0,        2'b01, 1'b1};
        tbl[6]  = '{1'b0, 16'h0002, 32'h0,        32'h1,        32'h1,        2'b01, 1'b1};
        tbl[7]  = '{1'b0, 16'h4000, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 1'b1};
        tbl[8]  = '{1'b0, 16'h4004, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 1'b1};
        tbl[9]  = '{1'b0, 16'h400C, 32'h0,        32'hFFFFFFFF, 32'h0,        2'b01, 1'b1};
        tbl[10] = '{1'b0, 16'h8000, 32'h0,        32'h0,        32'h0,        2'b01, 1'b1};
        tbl[11] = '{1'b0, 16'h0008, 32'h0,        32'h0,        32'h0,        2'b01, 1'b1};
        tbl[12] = '{1'b1, 16'h8000, 32'h1234,     32'h0,        32'h0,        2'b01, 1'b1};
        tbl[13] = '{1'b1, 16'h0008, 32'h1,        32'h0,        32'h0,        2'b01, 1'b1};
        tbl[14] = '{1'b1, 16'h0000, 32'h0,        32'h0,        32'h0,        2'b00, 1'b0};
        tbl[15] = '{1'b1, 16'h400C, 32'h0,        32'h0,        32'h0,        2'b00, 1'b0};
        tbl[16] = '{1'b0, 16'h400C, 32'h0,        32'h0,        32'h0,        2'b00, 1'b0};
        tbl[17] = '{1'b1, 16'h4008, 32'h0,        32'h0,        32'h0,        2'b00, 1'b0};
        tbl[18] = '{1'b1, 16'h400C, 32'hFFFFFFFF, 32'h0,        32'h0,        2'b00, 1'b0};

        @(negedge CLK);
        do_reset();

        repeat (4) @(negedge CLK);
        check("mtime_a_c4", mtime_a, 64'd1);
        check("mtime_b_c4", mtime_b, 64'd4);
        repeat (16) @(negedge CLK);
        check("mtime_a_c20", mtime_a, 64'd5);
        check("mtime_b_c20", mtime_b, 64'd20);

        for (int i = 0; i < 19; i++) begin
            bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, ra, rb);
            if (!tbl[i].we) begin
                check("tbl_rd_a", 64'(ra), 64'(tbl[i].exp_a));
                check("tbl_rd_b", 64'(rb), 64'(tbl[i].exp_b));
            end
            check("tbl_msip_a", 64'(msip_a), 64'(tbl[i].msip_a));
            check("tbl_msip_b", 64'(msip_b), 64'(tbl[i].msip_b));
        end

        do_reset();
        bus(1'b1, 16'h4004, 32'h0, ra, rb);
        bus(1'b1, 16'h4000, 32'd10, ra, rb);
        t = 0;
        while (mtime_b != 64'd10 && t < 50) begin
            @(negedge CLK);
            t++;
        end
        check("wait_mtime10", mtime_b, 64'd10);
        check("mtip_b_at10", 64'(mtip_b), 64'd0);
        @(negedge CLK);
        check("mtip_b_rise", 64'(mtip_b), 64'd1);
        idle(1);
        bus(1'b1, 16'h4004, 32'hFFFFFFFF, ra, rb);
        check("mtip_b_hold", 64'(mtip_b), 64'd1);
        @(negedge CLK);
        in_resp = 1'b0;
        check("mtip_b_fall", 64'(mtip_b), 64'd0);

        bus(1'b1, 16'hBFFC, 32'hFFFFFFFF, ra, rb);
        bus(1'b1, 16'hBFF8, 32'hFFFFFFFF, ra, rb);
        check("wrap_a_ones", mtime_a, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wrap_b_ones", mtime_b, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge CLK);
        in_resp = 1'b0;
        check("wrap_b_zero", mtime_b, 64'd0);
        for (int i = 0; i < 8 && mtime_a == 64'hFFFF_FFFF_FFFF_FFFF; i++) @(negedge CLK);
        check("wrap_a_zero", mtime_a, 64'd0);

        idle(1);
        for (int i = 0; i < 4 && (m_cyc % 4) != 2; i++) @(negedge CLK);
        bus(1'b1, 16'hBFF8, 32'h55, ra, rb);
        check("coll_a_55", 64'(mtime_a[31:0]), 64'h55);
        check("coll_b_55", 64'(mtime_b[31:0]), 64'h55);
        repeat (3) @(negedge CLK);
        in_resp = 1'b0;
        check("coll_a_hold", 64'(mtime_a[31:0]), 64'h55);
        @(negedge CLK);
        check("coll_a_56", 64'(mtime_a[31:0]), 64'h56);

        for (int i = 0; i < 200; i++) begin
            case ($urandom % 4)
                0: d = 32'h0;
                1: d = 32'($urandom % 16);
                2: d = 32'hFFFFFFFF;
                default: d = $urandom;
            endcase
            bus(1'($urandom % 2), alist[$urandom % 12], d, ra, rb);
            idle(int'($urandom % 3));
        end

        idle(1);
        w_req = 1'b1; w_we = 1'b1; w_addr = 16'h0004; w_wdata = 32'h1;
        @(negedge CLK);
        RST_X = 1'b0;
        w_req = 1'b0;
        #1;
        check("abort_ack0", 64'(ack_a), 64'd0);
        check("abort_busy0", 64'(busy_a), 64'd0);
        repeat (2) begin
            @(negedge CLK);
            check("abort_noack", 64'(ack_a), 64'd0);
        end
        RST_X = 1'b1;
        in_resp = 1'b0;
        repeat (3) @(negedge CLK);
        check("abort_msip", 64'(msip_a), 64'd0);
        check("abort_idle_ack", 64'(ack_a), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clint_smp.md
# clint_smp

Core-local interruptor for the multi-hart RV cluster. It owns the 64-bit `mtime` counter plus per-hart `mtimecmp` and `msip` registers, and exposes them as a memory-mapped 32-bit slave on the device side of the interconnect. It drives the `w_mtime`, `w_mtip[N_HARTS-1:0]` and `w_msip[N_HARTS-1:0]` inputs of the cluster, so it sits directly upstream of the hart cluster's interrupt inputs.

## Interface
- `N_HARTS`, default 1: number of harts; sets the widths of `w_mtip`/`w_msip` and the number of `msip`/`mtimecmp` registers.
- `TICK_DIV`, default 100: CLK cycles per `mtime` increment; must be ≥1.
- Ports:
  - `CLK` in 1: the block's single clock.
  - `RST_X` in 1: reset, asynchronous, active-low.
  - `w_req` in 1: request valid; held stable until `r_ack`.
  - `w_we` in 1: 1 = write, 0 = read.
  - `w_addr` in 16: byte offset inside the CLINT window; bits [1:0] are ignored.
  - `w_wdata` in 32: write data (full word only).
  - `r_rdata` out 32: read data, valid when `r_ack`=1.
  - `r_ack` out 1: one-cycle completion pulse.
  - `w_busy` out 1: high from acceptance through the `r_ack` cycle.
  - `w_mtime` out 64: current `mtime`.
  - `w_mtip` out N_HARTS: registered timer interrupt per hart.
  - `w_msip` out N_HARTS: software interrupt per hart (bit 0 of each `msip` register).

## Operation
- Address map (word offsets):
  - `0x0000 + 4*h`: `msip[h]`. Only bit 0 is stored; reads return `{31'b0, msip[h]}`.
  - `0x4000 + 8*h`: `mtimecmp[h]` low word.
  - `0x4004 + 8*h`: `mtimecmp[h]` high word.
  - `0xBFF8`: `mtime` low word. `0xBFFC`: `mtime` high word.
  - Any offset with h ≥ N_HARTS, and any other offset, is unmapped. Unmapped reads return 0; unmapped writes are dropped. Unmapped accesses are still acked.
- Bus FSM:
  - States `IDLE`, `ACCESS`, `RESP`.
  - `IDLE` → `ACCESS` on `w_req`. The address, `we` and `wdata` are latched at that point.
  - `ACCESS` performs the register write or read-mux capture → `RESP`.
  - `RESP` pulses `r_ack` with `r_rdata` valid → `IDLE`.
  - `w_req` seen in `RESP` is not accepted. It is accepted in the following `IDLE` cycle, which is how back-to-back requests are handled.
- Prescaler:
  - `r_div` counts 0..TICK_DIV-1 and wraps to 0.
  - A tick is asserted in the cycle `r_div`==TICK_DIV-1. On a tick, `mtime <= mtime + 1` as a full 64-bit add, wrapping at 2^64-1 → 0.
- Writes to `mtime`:
  - A write replaces only the addressed half; the other half holds.
  - A write and a tick in the same cycle: the write wins and the tick is lost for that cycle. `r_div` still advances.
  - Writing either half of `mtime` does not reset `r_div`.
- Comparison: `w_mtip[h] <= (mtime >= mtimecmp[h])`, unsigned 64-bit, registered every cycle.
- Writes to `mtimecmp`: a write to either half takes effect on the compare in the next cycle. Software writes the high word as all-ones first to avoid a spurious pulse; the block does not interlock this.

## Timing
- Reset values, applied asynchronously on `RST_X`=0:
  - `mtime`=0, `r_div`=0, every `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, every `msip`=0.
  - `w_mtip`=0, `r_ack`=0, `r_rdata`=0, `w_busy`=0, FSM=`IDLE`.
- Access latency: `w_req` sampled in cycle 0 → `r_ack` in cycle 2. Throughput is one access every 3 cycles.
- Write visibility:
  - `msip`: `w_msip` changes in cycle 2, the same cycle as `r_ack`.
  - `mtimecmp`: `w_mtip` reflects the new value in cycle 3.
- Reads sample register values at the `ACCESS` cycle.
- `w_mtime` is the register output directly. `w_mtip` lags `mtime` by one cycle.
- Reset asserted mid-transaction aborts it with no `r_ack`. The requester must re-issue after reset.

## Test plan
- Reset, then idle with TICK_DIV=4 → `w_mtime` reaches 1 at cycle 4 and 5 at cycle 20; `w_mtip`=0 and `w_msip`=0 throughout.
- Write `0x0004`=1 with N_HARTS=2 → `w_msip`=2'b10 on the `r_ack` cycle; read `0x0004` → `r_rdata`=1; write 0 → `w_msip`=0.
- Write `mtimecmp[0]`: high word 0, then low word 10, with TICK_DIV=1 → `w_mtip[0]` rises the cycle after `mtime`=10. Then write the high word as FFFF_FFFF → `w_mtip[0]` falls one cycle after that write.
- Write `mtime` low=FFFF_FFFF and high=FFFF_FFFF → after the next tick, `w_mtime`=0.
- Write `mtime` low=0x55 in the same cycle as a tick → `mtime` low=0x55 with no increment; the next tick gives 0x56.
- Read `0x8000`, and read `0x0008` with N_HARTS=2 → `r_rdata`=0 and `r_ack` pulses; a write to `0x8000` leaves all state unchanged.
